// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: runs one multiplexed address/data bus cycle (addr, gap, data, gap) to the RTC chip per CPU strobe.
module rtc_bus_ctrl #(
  parameter int T_PHASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act_rtc,
  input  logic [7:0] dir,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;
  state_t state, nxt;
  logic [7:0] cnt, nxt_cnt, addr_q, data_q, next_addr, next_data, o_ad_out;
  logic is_read, next_read, start, last, wdata, o_ad_oe, o_cs_n, o_rd_n, o_wr_n, o_a_d;
  always_comb begin
    start = state == IDLE && act_rtc && (write_strobe || read_strobe);
    last = cnt == 8'(T_PHASE - 1);
    nxt = state;
    if (start) nxt = ADDR;
    else if (state != IDLE && last)
      nxt = state == ADDR ? GAP1 : state == GAP1 ? DATA : state == DATA ? GAP2 : IDLE;
    nxt_cnt = (nxt != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
    next_addr = start ? dir : addr_q;
    next_data = start ? out_port : data_q;
    next_read = start ? read_strobe & ~write_strobe : is_read;
    // Outputs are decoded from the next state so the registered pins line up with the state they describe
    wdata = nxt == DATA && !next_read;
    o_ad_oe = nxt == ADDR || nxt == GAP1 || wdata;
    o_ad_out = (nxt == ADDR || nxt == GAP1) ? next_addr : wdata ? next_data : 8'd0;
    o_cs_n = !(nxt == ADDR || nxt == DATA);
    o_wr_n = !(nxt == ADDR || wdata);
    o_rd_n = !(nxt == DATA && next_read);
    o_a_d = !(nxt == ADDR || nxt == GAP1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      is_read <= 1'b0;
      ad_out <= '0;
      ad_oe <= 1'b0;
      cs_n <= 1'b1;
      rd_n <= 1'b1;
      wr_n <= 1'b1;
      a_d <= 1'b1;
      rd_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      addr_q <= next_addr;
      data_q <= next_data;
      is_read <= next_read;
      ad_out <= o_ad_out;
      ad_oe <= o_ad_oe;
      cs_n <= o_cs_n;
      rd_n <= o_rd_n;
      wr_n <= o_wr_n;
      a_d <= o_a_d;
      busy <= nxt != IDLE;
      done <= state == GAP2 && last;
      if (state == DATA && is_read && last) rd_data <= ad_in;
    end
  end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: vector table, corner sequences and random traffic against a cycle-count reference model.
module tb_rtc_bus_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, reset, act_rtc, write_strobe, read_strobe;
  logic [7:0] dir, out_port, ad_in, ad_out, rd_data;
  logic ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
  int n_cmp = 0, n_err = 0;
  int k = 0;
  logic [7:0] m_addr = 0, m_data = 0, m_rd = 0;
  bit m_read = 0, m_done = 0;
  always #5 clk = ~clk;
  rtc_bus_ctrl #(.T_PHASE(T)) dut (
    .clk(clk), .reset(reset), .act_rtc(act_rtc), .dir(dir), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .rd_data(rd_data), .busy(busy), .done(done)
  );
  typedef struct {
    bit act, ws, rs;
    logic [7:0] dir, dat, adin;
    int exp_lat;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[7];
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // k counts cycles since the start strobe (0 = idle); each quarter of 4*T is one bus phase
  task automatic check();
    int p;
    bit e_oe;
    p = k == 0 ? -1 : (k - 1) / T;
    e_oe = p == 0 || p == 1 || (p == 2 && !m_read);
    compare("bus", {ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, rd_data},
            {e_oe, !(p == 0 || p == 2), !(p == 2 && m_read), !(p == 0 || (p == 2 && !m_read)),
             !(p == 0 || p == 1), k != 0, m_done, m_rd});
    if (e_oe || k == 0) compare("ad_out", ad_out, k == 0 ? 8'd0 : p < 2 ? m_addr : m_data);
  endtask
  task automatic step();
    @(posedge clk);
    if (reset) begin
      k = 0;
      m_done = 0;
      m_rd = 0;
    end else begin
      m_done = k == 4 * T;
      if (k == 3 * T && m_read) m_rd = ad_in;
      if (k == 0) begin
        if (act_rtc && (write_strobe || read_strobe)) begin
          k = 1;
          m_addr = dir;
          m_data = out_port;
          m_read = read_strobe && !write_strobe;
        end
      end else if (k == 4 * T) k = 0;
      else k++;
    end
    #1 check();
  endtask
  initial begin
    int lat, n_done;
    vecs[0] = '{1, 1, 0, 8'h21, 8'h45, 8'h00, 17, 8'h00};
    vecs[1] = '{1, 0, 1, 8'h22, 8'h00, 8'h59, 17, 8'h59};
    vecs[2] = '{1, 1, 0, 8'h30, 8'h77, 8'hAA, 17, 8'h59};
    vecs[3] = '{0, 1, 0, 8'h31, 8'h78, 8'hBB, 0, 8'h59};
    vecs[4] = '{1, 1, 1, 8'h10, 8'h3C, 8'h11, 17, 8'h59};
    vecs[5] = '{0, 0, 1, 8'h32, 8'h00, 8'h12, 0, 8'h59};
    vecs[6] = '{1, 0, 1, 8'h7F, 8'h00, 8'hA5, 17, 8'hA5};
    {act_rtc, write_strobe, read_strobe, dir, out_port, ad_in} = '0;
    reset = 1;
    repeat (3) step();
    reset = 0;
    step();
    for (int v = 0; v < 7; v++) begin
      act_rtc = vecs[v].act;
      write_strobe = vecs[v].ws;
      read_strobe = vecs[v].rs;
      dir = vecs[v].dir;
      out_port = vecs[v].dat;
      ad_in = vecs[v].adin;
      step();
      {act_rtc, write_strobe, read_strobe} = '0;
      lat = 0;
      for (int i = 1; i <= 24; i++) begin
        step();
        if (done && lat == 0) lat = i + 1;
      end
      compare("latency", lat, vecs[v].exp_lat);
      compare("rd_data", rd_data, vecs[v].exp_rd);
    end
    // strobe while busy is dropped; strobe in the done cycle starts a new read
    act_rtc = 1;
    write_strobe = 1;
    dir = 8'h40;
    out_port = 8'h41;
    ad_in = 8'h6C;
    step();
    n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      {write_strobe, read_strobe} = '0;
      if (i == 5) write_strobe = 1;
      if (done && n_done == 0) read_strobe = 1;
      if (done) n_done++;
    end
    compare("done_count", n_done, 2);
    compare("rd_after_chain", rd_data, 8'h6C);
    // reset in the middle of a write data phase
    write_strobe = 1;
    step();
    write_strobe = 0;
    repeat (9) step();
    reset = 1;
    step();
    reset = 0;
    compare("reset_release", {cs_n, wr_n, ad_oe, busy}, 4'b1100);
    n_done = 0;
    repeat (25) begin
      step();
      if (done) n_done++;
    end
    compare("no_done_after_reset", n_done, 0);
    for (int i = 0; i < 500; i++) begin
      reset = $urandom_range(0, 99) == 0;
      act_rtc = $urandom_range(0, 3) != 0;
      write_strobe = $urandom_range(0, 7) == 0;
      read_strobe = $urandom_range(0, 7) == 0;
      dir = 8'($urandom);
      out_port = 8'($urandom);
      ad_in = 8'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
